// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame checker: parity modes,
// error_flag bit positions and the output-register state.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam int ERR_PARITY = 0;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 2;
    localparam int ERR_BREAK  = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/uart_sat_counter.sv
// Statistics counter that sticks at all-ones; a clear in the same
// cycle as an increment leaves a count of one.
module uart_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/uart_frame_checker.sv
// Checks sampled UART frames for parity, framing and break errors,
// registers the result behind a valid/ready slot and keeps statistics.
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start_bit,
    input  logic [STOP_BITS-1:0] stop_bits,
    input  logic                 parity_bit,
    input  logic [DATA_BITS-1:0] raw_data,
    input  logic [1:0]           parity_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [3:0]           error_flag,
    output logic [3:0]           status_sticky,
    input  logic                 status_clear,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] parity_err_cnt,
    output logic [CNT_WIDTH-1:0] framing_err_cnt,
    output logic [CNT_WIDTH-1:0] break_cnt
);

    localparam bit PAR_BUILT = (PARITY_EN != 0);

    state_t     state;
    logic       in_xfer;
    logic       out_xfer;
    logic       parity_on;
    logic       exp_par;
    logic       is_break;
    logic [3:0] frame_flags;

    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign parity_on = PAR_BUILT &&
                       ((parity_type == PAR_ODD) ||
                        (parity_type == PAR_EVEN));
    assign exp_par   = (parity_type == PAR_EVEN) ? ^raw_data
                                                 : ~^raw_data;

    // A line held low for the whole frame is a break, not a bad frame.
    assign is_break  = !start_bit && (raw_data == '0) &&
                       (stop_bits == '0) &&
                       (!parity_on || !parity_bit);

    always_comb begin
        frame_flags = '0;
        if (is_break) begin
            frame_flags[ERR_BREAK] = 1'b1;
        end else begin
            frame_flags[ERR_PARITY] = parity_on &&
                                      (parity_bit != exp_par);
            frame_flags[ERR_START]  = start_bit;
            frame_flags[ERR_STOP]   = !(&stop_bits);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_EMPTY;
            out_data      <= '0;
            error_flag    <= '0;
            status_sticky <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: if (in_xfer) state <= ST_FULL;
                ST_FULL:  if (out_xfer && !in_xfer) state <= ST_EMPTY;
            endcase
            if (in_xfer) begin
                out_data   <= raw_data;
                error_flag <= frame_flags;
            end
            if (status_clear) begin
                status_sticky <= in_xfer ? frame_flags : 4'b0000;
            end else if (in_xfer) begin
                status_sticky <= status_sticky | frame_flags;
            end
        end
    end

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (in_xfer),
        .clr     (status_clear),
        .count   (frame_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (in_xfer && frame_flags[ERR_PARITY]),
        .clr     (status_clear),
        .count   (parity_err_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_framing_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (in_xfer && (frame_flags[ERR_START] ||
                              frame_flags[ERR_STOP])),
        .clr     (status_clear),
        .count   (framing_err_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_break_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (in_xfer && frame_flags[ERR_BREAK]),
        .clr     (status_clear),
        .count   (break_cnt)
    );

endmodule

// File: tb/tb_uart_frame_checker.sv
// Randomised and directed bench for uart_frame_checker against a
// queue-based reference model of the result slot and statistics.
module tb_uart_frame_checker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid, start_bit, parity_bit;
    logic [1:0]  stop_bits, parity_type;
    logic [7:0]  raw_data;
    logic        out_ready, status_clear;

    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [3:0]  error_flag, status_sticky;
    logic [15:0] frame_cnt, parity_err_cnt, framing_err_cnt, break_cnt;

    logic        in_ready_s, out_valid_s;
    logic [7:0]  out_data_s;
    logic [3:0]  error_flag_s, sticky_s;
    logic [3:0]  frame_cnt_s, parity_cnt_s, framing_cnt_s, break_cnt_s;

    always #5 clock = ~clock;

    uart_frame_checker #(
        .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .start_bit(start_bit), .stop_bits(stop_bits),
        .parity_bit(parity_bit), .raw_data(raw_data),
        .parity_type(parity_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .error_flag(error_flag),
        .status_sticky(status_sticky), .status_clear(status_clear),
        .frame_cnt(frame_cnt), .parity_err_cnt(parity_err_cnt),
        .framing_err_cnt(framing_err_cnt), .break_cnt(break_cnt)
    );

    uart_frame_checker #(
        .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2), .CNT_WIDTH(4)
    ) dut_s (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .start_bit(start_bit), .stop_bits(stop_bits),
        .parity_bit(parity_bit), .raw_data(raw_data),
        .parity_type(parity_type),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .error_flag(error_flag_s),
        .status_sticky(sticky_s), .status_clear(status_clear),
        .frame_cnt(frame_cnt_s), .parity_err_cnt(parity_cnt_s),
        .framing_err_cnt(framing_cnt_s), .break_cnt(break_cnt_s)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
    } res_t;

    res_t       q[$];
    int         fc, pc, frc, bc;
    logic [3:0] stk;
    bit         last_acc;
    int         tests = 0;
    int         fails = 0;

    function automatic logic [3:0] ref_flags(
        input logic s, input logic [1:0] sp, input logic p,
        input logic [7:0] d, input logic [1:0] pt);
        logic [3:0] r;
        bit pon;
        bit epar;
        int ones;
        pon  = (pt == 2'b01) || (pt == 2'b10);
        ones = $countones(d);
        epar = (pt == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
        if (!s && d == 8'h00 && sp == 2'b00 && (!pon || !p))
            return 4'b1000;
        r    = 4'b0000;
        r[0] = pon && (p != epar);
        r[1] = s;
        r[2] = (sp != 2'b11);
        return r;
    endfunction

    function automatic logic good_par(input logic [7:0] d,
                                      input logic [1:0] pt);
        int ones;
        ones = $countones(d);
        if (pt == 2'b10) return logic'(ones % 2 == 1);
        if (pt == 2'b01) return logic'(ones % 2 == 0);
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        q.delete();
        fc = 0; pc = 0; frc = 0; bc = 0;
        stk = 4'b0000;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        status_clear = 1'b0;
    endtask

    task automatic set_frame(input logic s, input logic [1:0] sp,
                             input logic p, input logic [7:0] d,
                             input logic [1:0] pt);
        in_valid = 1'b1;
        start_bit = s; stop_bits = sp; parity_bit = p;
        raw_data = d; parity_type = pt;
    endtask

    // One clock of the reference model; time is posedge+1 on return.
    task automatic tick();
        bit ir, ix, ox;
        logic [3:0] f;
        ir = (q.size() == 0) || out_ready;
        ix = in_valid && ir;
        ox = (q.size() != 0) && out_ready;
        f  = ref_flags(start_bit, stop_bits, parity_bit,
                       raw_data, parity_type);
        @(posedge clock);
        if (ox) void'(q.pop_front());
        if (status_clear) begin
            fc = 0; pc = 0; frc = 0; bc = 0;
            stk = 4'b0000;
        end
        if (ix) begin
            q.push_back('{raw_data, f});
            fc++;
            if (f[0]) pc++;
            if (f[1] || f[2]) frc++;
            if (f[3]) bc++;
            stk = stk | f;
        end
        last_acc = ix;
        #1;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b1;
        set_frame(1'b0, 2'b11, 1'b0, 8'h00, 2'b00);
        in_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            error_flag !== 4'h0 || status_sticky !== 4'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h f=%b s=%b want 0",
                     out_valid, out_data, error_flag, status_sticky);
        end
        tests++;
        if (frame_cnt !== 0 || parity_err_cnt !== 0 ||
            framing_err_cnt !== 0 || break_cnt !== 0) begin
            fails++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d want 0",
                     frame_cnt, parity_err_cnt, framing_err_cnt,
                     break_cnt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_even_parity();
        out_ready = 1'b1;
        set_frame(1'b0, 2'b11, 1'b0, 8'h55, 2'b10);
        tick();
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 ||
            error_flag !== 4'b0000 || frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL even_parity: got v=%b d=%h f=%b n=%0d want 1 55 0000 1",
                     out_valid, out_data, error_flag, frame_cnt);
        end
        tick();
    endtask

    task automatic test_odd_and_clear();
        idle();
        status_clear = 1'b1;
        tick();
        set_frame(1'b0, 2'b11, 1'b0, 8'h55, 2'b01);
        tick();
        idle();
        tests++;
        if (error_flag !== 4'b0001 || parity_err_cnt !== 16'd1 ||
            status_sticky !== 4'b0001) begin
            fails++;
            $display("FAIL odd_parity: got f=%b p=%0d s=%b want 0001 1 0001",
                     error_flag, parity_err_cnt, status_sticky);
        end
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        tests++;
        if (status_sticky !== 4'b0000 || frame_cnt !== 0 ||
            parity_err_cnt !== 0 || framing_err_cnt !== 0 ||
            break_cnt !== 0) begin
            fails++;
            $display("FAIL status_clear: got s=%b n=%0d p=%0d want 0",
                     status_sticky, frame_cnt, parity_err_cnt);
        end
        set_frame(1'b1, 2'b11, 1'b0, 8'h55, 2'b10);
        status_clear = 1'b1;
        tick();
        idle();
        tests++;
        if (status_sticky !== 4'b0010 || frame_cnt !== 16'd1 ||
            framing_err_cnt !== 16'd1) begin
            fails++;
            $display("FAIL clear_with_frame: got s=%b n=%0d fr=%0d want 0010 1 1",
                     status_sticky, frame_cnt, framing_err_cnt);
        end
        tick();
    endtask

    task automatic test_framing();
        int exp_fr;
        exp_fr = frc + 1;
        out_ready = 1'b1;
        set_frame(1'b1, 2'b01, 1'b0, 8'h55, 2'b10);
        tick();
        idle();
        tests++;
        if (error_flag !== 4'b0110 || framing_err_cnt !== 16'(exp_fr)) begin
            fails++;
            $display("FAIL framing: got f=%b fr=%0d want 0110 %0d",
                     error_flag, framing_err_cnt, exp_fr);
        end
        tick();
    endtask

    task automatic test_break();
        int exp_b;
        int exp_p;
        exp_b = bc + 1;
        exp_p = pc;
        out_ready = 1'b1;
        set_frame(1'b0, 2'b00, 1'b0, 8'h00, 2'b10);
        tick();
        idle();
        tests++;
        if (error_flag !== 4'b1000 || break_cnt !== 16'(exp_b) ||
            parity_err_cnt !== 16'(exp_p)) begin
            fails++;
            $display("FAIL break: got f=%b b=%0d p=%0d want 1000 %0d %0d",
                     error_flag, break_cnt, parity_err_cnt, exp_b, exp_p);
        end
        set_frame(1'b0, 2'b00, 1'b1, 8'h00, 2'b00);
        tick();
        idle();
        tests++;
        if (error_flag !== 4'b1000 || break_cnt !== 16'(exp_b + 1)) begin
            fails++;
            $display("FAIL break_no_parity: got f=%b b=%0d want 1000 %0d",
                     error_flag, break_cnt, exp_b + 1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr [3];
        int k;
        int e;
        int cyc;
        for (int i = 0; i < 3; i++) fr[i] = 8'($urandom_range(1, 255));
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_frame(1'b0, 2'b11, good_par(fr[k], 2'b10), fr[k], 2'b10);
            tick();
            if (last_acc) k++;
            tests++;
            if (out_valid !== 1'b1 || out_data !== fr[0] ||
                error_flag !== 4'b0000 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: got v=%b d=%h f=%b r=%b want 1 %h 0000 0",
                         out_valid, out_data, error_flag, in_ready, fr[0]);
            end
        end
        tests++;
        if (k !== 1) begin
            fails++;
            $display("FAIL stall_accept: got %0d accepted want 1", k);
        end
        out_ready = 1'b1;
        e = 0;
        cyc = 0;
        while (e < 3 && cyc < 10) begin
            if (k < 3)
                set_frame(1'b0, 2'b11, good_par(fr[k], 2'b10),
                          fr[k], 2'b10);
            else
                idle();
            #1;
            if (out_valid === 1'b1) begin
                tests++;
                if (out_data !== fr[e]) begin
                    fails++;
                    $display("FAIL order_%0d: got %h want %h",
                             e, out_data, fr[e]);
                end
                e++;
            end
            tick();
            if (last_acc) k++;
            cyc++;
        end
        idle();
        tests++;
        if (e !== 3 || cyc !== 3) begin
            fails++;
            $display("FAIL drain_rate: got %0d frames in %0d cycles want 3 in 3",
                     e, cyc);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        idle();
        out_ready = 1'b1;
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            set_frame(1'b0, 2'b11, ~good_par(d, 2'b10), d, 2'b10);
            tick();
        end
        idle();
        tests++;
        if (parity_cnt_s !== 4'd15 || frame_cnt_s !== 4'd15 ||
            parity_err_cnt !== 16'd20) begin
            fails++;
            $display("FAIL saturate: got small p=%0d n=%0d big p=%0d want 15 15 20",
                     parity_cnt_s, frame_cnt_s, parity_err_cnt);
        end
        tick();
        out_ready = 1'b0;
        set_frame(1'b0, 2'b11, 1'b0, 8'hA5, 2'b00);
        tick();
        idle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_valid_s !== 1'b0 ||
            out_data !== 8'h00 || frame_cnt !== 0 ||
            parity_err_cnt !== 0 || parity_cnt_s !== 0 ||
            frame_cnt_s !== 0 || break_cnt !== 0) begin
            fails++;
            $display("FAIL async_reset: got v=%b d=%h n=%0d p=%0d ps=%0d want 0",
                     out_valid, out_data, frame_cnt, parity_err_cnt,
                     parity_cnt_s);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        int mode;
        logic [7:0] d;
        logic [1:0] pt;
        for (int c = 0; c < 400; c++) begin
            mode = $urandom_range(0, 9);
            d    = 8'($urandom);
            pt   = 2'($urandom);
            if (mode < 2)
                set_frame(1'b0, 2'b00, 1'b0, 8'h00, pt);
            else if (mode < 6)
                set_frame(1'b0, 2'b11, good_par(d, pt), d, pt);
            else
                set_frame(1'($urandom), 2'($urandom),
                          1'($urandom), d, pt);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            status_clear = ($urandom_range(0, 19) == 0);
            #1;
            tests++;
            if (in_ready !== ((q.size() == 0) || out_ready)) begin
                fails++;
                $display("FAIL rnd_in_ready@%0d: got %b", c, in_ready);
            end
            tick();
            tests++;
            if (out_valid !== (q.size() != 0)) begin
                fails++;
                $display("FAIL rnd_valid@%0d: got %b want %b",
                         c, out_valid, q.size() != 0);
            end else if (q.size() != 0) begin
                tests++;
                if (out_data !== q[0].d || error_flag !== q[0].f) begin
                    fails++;
                    $display("FAIL rnd_data@%0d: got %h/%b want %h/%b",
                             c, out_data, error_flag, q[0].d, q[0].f);
                end
            end
            tests++;
            if (status_sticky !== stk || frame_cnt !== 16'(fc) ||
                parity_err_cnt !== 16'(pc) ||
                framing_err_cnt !== 16'(frc) ||
                break_cnt !== 16'(bc)) begin
                fails++;
                $display("FAIL rnd_stats@%0d: got %b %0d %0d %0d %0d want %b %0d %0d %0d %0d",
                         c, status_sticky, frame_cnt, parity_err_cnt,
                         framing_err_cnt, break_cnt, stk, fc, pc, frc, bc);
            end
            tests++;
            if (frame_cnt_s !== 4'(sat(fc, 15)) ||
                parity_cnt_s !== 4'(sat(pc, 15)) ||
                framing_cnt_s !== 4'(sat(frc, 15)) ||
                break_cnt_s !== 4'(sat(bc, 15))) begin
                fails++;
                $display("FAIL rnd_sat@%0d: got %0d %0d %0d %0d",
                         c, frame_cnt_s, parity_cnt_s,
                         framing_cnt_s, break_cnt_s);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_and_clear();
        test_framing();
        test_break();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_checker.md
UART_FRAME_CHECKER -- requirements
Module: uart_frame_checker

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PARITY_EN, default 1, meaning parity checking is built (0 = parity logic removed, parity error never set).
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of each statistics counter.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning a received frame is presented.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts the frame this cycle.
REQ-009 The block SHALL have ports start_bit (1), stop_bits (STOP_BITS), parity_bit (1) and raw_data (DATA_BITS), all inputs, holding the sampled frame fields.
REQ-010 The block SHALL have port parity_type, input, 2, encoded as 00 none, 01 odd, 10 even, 11 none.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the result handshake.
REQ-012 The block SHALL have ports out_data (output, DATA_BITS) and error_flag (output, 4), where error_flag bits are [0] parity, [1] start, [2] stop, [3] break.
REQ-013 The block SHALL have port status_sticky, output, 4, holding the OR of all error_flag values since the last clear.
REQ-014 The block SHALL have port status_clear, input, 1, a single-cycle pulse that clears status_sticky and all counters.
REQ-015 The block SHALL have ports frame_cnt, parity_err_cnt, framing_err_cnt and break_cnt, all outputs of width CNT_WIDTH.

Function
REQ-016 A frame SHALL transfer on a cycle where in_valid and in_ready are both 1, and a result SHALL transfer on a cycle where out_valid and out_ready are both 1.
REQ-017 The block SHALL drive in_ready = !out_valid || out_ready, so a single output register gives full throughput with no bubble.
REQ-018 The block SHALL use a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 EMPTY SHALL go to FULL on an input transfer; FULL SHALL stay FULL on simultaneous input and output transfers, go to EMPTY on an output transfer with no input, and hold otherwise.
REQ-020 Latency from input transfer to out_valid=1 SHALL be exactly 1 cycle.
REQ-021 out_data and error_flag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 With parity_type 10, expected parity SHALL be ^raw_data; with 01, expected parity SHALL be ~^raw_data; with 00 or 11, error_flag[0] SHALL be 0.
REQ-023 error_flag[1] SHALL be set when start_bit=1, and error_flag[2] SHALL be set when any stop_bits bit is 0.
REQ-024 Break SHALL be detected when start_bit=0, raw_data=0, every stop_bits bit is 0, and parity_bit=0 (parity_bit is ignored when parity is off); on a break, error_flag SHALL be 4'b1000 only.
REQ-025 On each input transfer, frame_cnt SHALL increment; parity_err_cnt SHALL increment if flag[0]; framing_err_cnt SHALL increment if flag[1] or flag[2] (once per frame); break_cnt SHALL increment if flag[3].
REQ-026 All counters SHALL saturate at all-ones and never wrap.
REQ-027 status_clear and an input transfer in the same cycle SHALL clear first and then apply the new frame, so the new frame's error bits and counts of 1 survive.
REQ-028 status_sticky and the counters SHALL update on input transfer, not output transfer.

Reset
REQ-029 While reset_n=0, the block SHALL be in EMPTY with out_valid=0, out_data=0, error_flag=0, status_sticky=0 and all counters=0; in_ready SHALL be 1 once reset is released.
REQ-030 Reset asserted mid-operation SHALL discard any held result immediately, without waiting for the clock.

Structure
REQ-031 The shared package uart_pkg SHALL hold the parity_type encodings, the error_flag bit indices and the EMPTY/FULL state encoding.
REQ-032 A single sub-module, uart_sat_counter (parameter CNT_WIDTH, with inc and clr inputs), SHALL be instantiated four times; all other logic SHALL be inline.

Verification
REQ-033 Even parity: data=0x55, parity=0, start=0, stop=1 -> one cycle later out_data=0x55, error_flag=0000, frame_cnt=1.
REQ-034 Odd parity: data=0x55, parity=0 -> error_flag=0001, parity_err_cnt=1; then status_clear -> status_sticky=0000 and counters=0.
REQ-035 Start=1 and stop=0 in one frame -> error_flag=0110 and framing_err_cnt increments by 1.
REQ-036 All-zero frame (STOP_BITS=2, stop=00) -> error_flag=1000, break_cnt=1, parity_err_cnt unchanged.
REQ-037 Hold out_ready=0 for 5 cycles with 3 frames offered -> one frame held stable, in_ready=0, the others stalled; then out_ready=1 -> frames delivered in order, one per cycle.
REQ-038 CNT_WIDTH=4 with 20 parity-error frames -> parity_err_cnt=15 (saturated); reset_n pulsed mid-stall -> out_valid=0 and all counters=0 immediately.
